// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream FIFO companion blocks.
package stream_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_e;

    // Ceiling log2 for sizing counters at elaboration time.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_burst_reader.sv
// Drains a FWFT stream FIFO into a burst sink: request with a length, wait
// for ack, then stream exactly that many beats with last on the final one.
module stream_burst_reader
    import stream_pkg::*;
#(
    parameter int DW      = 32,
    parameter int LW      = 10,
    parameter int BURST   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [LW-1:0] level_i,
    input  logic          flush_i,
    input  logic [DW-1:0] s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    output logic          burst_req_o,
    output logic [LW-1:0] burst_len_o,
    input  logic          burst_ack_i,
    output logic [DW-1:0] m_data_o,
    output logic          m_valid_o,
    output logic          m_last_o,
    input  logic          m_ready_i
);

    localparam int TW = (TIMEOUT > 1) ? clog2(TIMEOUT) : 1;

    if (BURST < 1 || BURST > (1 << LW) - 1) begin : g_bad_burst
        $error("stream_burst_reader: BURST must be in 1..2^LW-1");
    end

    state_e        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] beat_q, beat_d;
    logic [TW-1:0] tmo_q, tmo_d;

    logic full, partial, tmo_max, tmo_hit, in_xfer, beat_xfer;

    assign full      = level_i >= LW'(BURST);
    assign partial   = (level_i != '0) && !full;
    assign tmo_max   = tmo_q == TW'(TIMEOUT - 1);
    // TIMEOUT==0 disables forcing; the counter then just parks harmlessly.
    assign tmo_hit   = (TIMEOUT != 0) && tmo_max;
    assign in_xfer   = state_q == S_XFER;
    assign beat_xfer = m_valid_o && m_ready_i;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        beat_d  = beat_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (full) begin
                    len_d   = LW'(BURST);
                    state_d = S_REQ;
                    tmo_d   = '0;
                end else if (partial && (flush_i || tmo_hit)) begin
                    len_d   = level_i;
                    state_d = S_REQ;
                    tmo_d   = '0;
                end else if (!partial) begin
                    tmo_d   = '0;
                end else if (!tmo_max) begin
                    tmo_d   = tmo_q + 1'b1;
                end
            end
            S_REQ: begin
                if (burst_ack_i) begin
                    state_d = S_XFER;
                    beat_d  = len_q - 1'b1;
                end
            end
            S_XFER: begin
                if (beat_xfer) begin
                    if (beat_q == '0) state_d = S_IDLE;
                    else              beat_d  = beat_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
        end
    end

    // Data path is a straight pass-through while a burst is open.
    assign m_valid_o   = in_xfer && s_valid_i;
    assign s_ready_o   = in_xfer && m_ready_i;
    assign m_data_o    = in_xfer ? s_data_i : '0;
    assign m_last_o    = m_valid_o && (beat_q == '0);
    assign burst_req_o = state_q == S_REQ;
    assign burst_len_o = len_q;

endmodule

// File: tb/tb_stream_burst_reader.sv
// Directed bench: a FWFT FIFO model feeds the reader, sink handshakes are scripted.
module tb_stream_burst_reader;

    localparam int DW = 32;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic [LW-1:0] level_i;
    logic          flush_i;
    logic [DW-1:0] s_data_i;
    logic          s_valid_i;
    logic          s_ready_o;
    logic          burst_req_o;
    logic [LW-1:0] burst_len_o;
    logic          burst_ack_i;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_last_o;
    logic          m_ready_i;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:511];
    int  wr_ptr = 0;
    int  rd_ptr = 0;
    bit  drop   = 1'b0;

    always #5 clk = ~clk;

    assign level_i   = LW'(wr_ptr - rd_ptr);
    assign s_valid_i = wr_ptr != rd_ptr;
    assign s_data_i  = mem[rd_ptr];

    always @(posedge clk) begin
        if (drop)                        rd_ptr <= wr_ptr;
        else if (s_ready_o && s_valid_i) rd_ptr <= rd_ptr + 1;
    end

    stream_burst_reader #(.DW(DW), .LW(LW), .BURST(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .level_i(level_i), .flush_i(flush_i),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
        .burst_req_o(burst_req_o), .burst_len_o(burst_len_o), .burst_ack_i(burst_ack_i),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr] = DW'(wr_ptr);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    // Returns the number of negedges until burst_req_o is seen (0 = never).
    task automatic wait_req(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (burst_req_o) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic do_ack(input int delay, input int len);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk("req_held", burst_req_o, 1);
            chk("len_held", burst_len_o, len);
        end
        burst_ack_i = 1'b1;
        @(posedge clk);
        #1 burst_ack_i = 1'b0;
    endtask

    // Streams beats until `stop` transfers were seen; checks order, last, ready mirror.
    task automatic xfer(input int len, input int base, input bit toggle, input int stop);
        int n;
        n = 0;
        for (int c = 0; c < 200 && n < stop; c++) begin
            @(negedge clk);
            m_ready_i = toggle ? c[0] : 1'b1;
            #1;
            if (c == 0) chk("req_dropped", burst_req_o, 0);
            chk("s_ready_mirror", s_ready_o, m_ready_i);
            if (m_valid_o && m_ready_i) begin
                chk("beat_data", m_data_o, base + n);
                chk("beat_last", m_last_o, (n == len - 1));
                n++;
            end
        end
        chk("beat_count", n, stop);
    endtask

    task automatic idle_chk();
        @(negedge clk);
        chk("idle_req", burst_req_o, 0);
        chk("idle_valid", m_valid_o, 0);
        chk("idle_sready", s_ready_o, 0);
    endtask

    initial begin
        int cyc;
        bit seen;
        rst = 1'b1; flush_i = 1'b0; burst_ack_i = 1'b0; m_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", burst_req_o, 0);
        chk("rst_valid", m_valid_o, 0);
        chk("rst_sready", s_ready_o, 0);
        chk("rst_last", m_last_o, 0);
        chk("rst_len", burst_len_o, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("no_req_empty", burst_req_o, 0);

        // Full burst, data 0..15
        push(16);
        wait_req(cyc);
        chk("full_lat", cyc, 1);
        chk("full_len", burst_len_o, 16);
        do_ack(3, 16);
        xfer(16, 0, 1'b0, 16);
        idle_chk();

        // Backpressure, data 16..31
        push(16);
        wait_req(cyc);
        chk("bp_lat", cyc, 1);
        do_ack(1, 16);
        xfer(16, 16, 1'b1, 16);
        idle_chk();

        // Flush partial, data 32..36
        push(5); flush_i = 1'b1;
        wait_req(cyc);
        flush_i = 1'b0;
        chk("flush_lat", cyc, 1);
        chk("flush_len", burst_len_o, 5);
        do_ack(2, 5);
        xfer(5, 32, 1'b0, 5);
        idle_chk();

        // Timeout, data 37..39
        push(3);
        wait_req(cyc);
        chk("tmo_lat", cyc, 8);
        chk("tmo_len", burst_len_o, 3);
        do_ack(0, 3);
        xfer(3, 37, 1'b0, 3);
        idle_chk();

        // Level drops to 0 before timeout: no request, counter restarts
        push(3);
        repeat (4) @(negedge clk);
        drop = 1'b1;
        @(negedge clk);
        drop = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (burst_req_o) seen = 1'b1;
        end
        chk("tmo_cancel", seen, 0);
        push(3);
        wait_req(cyc);
        chk("tmo_restart_lat", cyc, 8);
        do_ack(0, 3);
        xfer(3, 43, 1'b0, 3);

        // Priority: flush with 40 words -> 16, 16, 8 (data 46..85)
        push(40); flush_i = 1'b1;
        wait_req(cyc);
        chk("prio1_lat", cyc, 2);
        chk("prio1_len", burst_len_o, 16);
        do_ack(0, 16);
        xfer(16, 46, 1'b0, 16);
        wait_req(cyc);
        chk("prio2_gap", cyc, 2);
        chk("prio2_len", burst_len_o, 16);
        do_ack(0, 16);
        xfer(16, 62, 1'b0, 16);
        wait_req(cyc);
        chk("prio3_gap", cyc, 2);
        chk("prio3_len", burst_len_o, 8);
        flush_i = 1'b0;
        do_ack(1, 8);
        xfer(8, 78, 1'b0, 8);
        idle_chk();

        // Async reset mid-burst after 6 of 16 beats (data 86..101)
        push(16);
        wait_req(cyc);
        chk("rb_lat", cyc, 1);
        do_ack(0, 16);
        xfer(16, 86, 1'b0, 6);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ar_valid", m_valid_o, 0);
        chk("ar_sready", s_ready_o, 0);
        chk("ar_last", m_last_o, 0);
        chk("ar_req", burst_req_o, 0);
        chk("ar_len", burst_len_o, 0);
        chk("ar_data", m_data_o, 0);
        chk("ar_fifo_kept", level_i, 10);
        @(negedge clk);
        rst = 1'b0;
        wait_req(cyc);
        chk("ar_next_lat", cyc, 8);
        chk("ar_next_len", burst_len_o, 10);
        do_ack(1, 10);
        xfer(10, 92, 1'b0, 10);
        idle_chk();
        chk("fifo_empty", level_i, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
